// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cache_pkg
// Description : Shared geometry and refill FSM encoding for the direct-mapped
//               cache miss-service path.
//               Byte address = {tag[8:0], index[7:0], offset[4:0]}, so the
//               line address is the upper 17 bits.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

  localparam int TAG_BITS       = 9;
  localparam int INDEX_BITS     = 8;
  localparam int OFFSET_BITS    = 5;
  localparam int LINE_ADDR_BITS = TAG_BITS + INDEX_BITS;
  localparam int BYTE_ADDR_BITS = LINE_ADDR_BITS + OFFSET_BITS;

  localparam int WORD_SIZE  = 32;
  localparam int BLOCK_SIZE = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    RD_REQ = 3'd2,
    BEATS  = 3'd3,
    FILL   = 3'd4
  } refill_state_t;

endpackage
`default_nettype wire

// File: rtl/cache_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : cache_write_buffer
// Description : Synchronous FIFO queueing write-through stores until they are
//               posted to memory.
// Ports       : clk, resetn        clock / async active-low reset
//               push, push_data    enqueue (ignored while full)
//               pop                dequeue head (ignored while empty)
//               head_data          current head entry
//               full, empty, count occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module cache_write_buffer #(
  parameter int WIDTH = 54,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Storage is not reset: entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_line_refill_unit.sv
`default_nettype none
// ============================================================================
// Module      : cache_line_refill_unit
// Description : Miss-service stage behind the direct-mapped cache. Fetches a
//               line as a read burst, returns it as a single-cycle fill, and
//               posts write-through stores from a small write buffer, always
//               draining the buffer before a refill read is issued.
// Ports       : miss_valid/ready/line     refill request from the cache
//               fill_valid/line/data      assembled line back to the cache
//               wt_valid/ready/addr/data  write-through store input
//               mem_req_*                 memory request (valid/ready)
//               mem_rvalid/rdata          read beats (no back-pressure)
//               busy                      refill active or stores pending
// Revision    : 1.0 - initial release
// ============================================================================
module cache_line_refill_unit
  import cache_pkg::*;
#(
  parameter int WORD_SIZE  = cache_pkg::WORD_SIZE,
  parameter int BLOCK_SIZE = cache_pkg::BLOCK_SIZE,
  parameter int ADDR_BITS  = cache_pkg::BYTE_ADDR_BITS,
  parameter int WB_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               miss_valid,
  output logic                               miss_ready,
  input  logic [ADDR_BITS-OFFSET_BITS-1:0]   miss_line,
  output logic                               fill_valid,
  output logic [ADDR_BITS-OFFSET_BITS-1:0]   fill_line,
  output logic [WORD_SIZE*BLOCK_SIZE-1:0]    fill_data,
  input  logic                               wt_valid,
  output logic                               wt_ready,
  input  logic [ADDR_BITS-1:0]               wt_addr,
  input  logic [WORD_SIZE-1:0]               wt_data,
  output logic                               mem_req_valid,
  input  logic                               mem_req_ready,
  output logic                               mem_req_write,
  output logic [ADDR_BITS-1:0]               mem_req_addr,
  output logic [WORD_SIZE-1:0]               mem_req_wdata,
  input  logic                               mem_rvalid,
  input  logic [WORD_SIZE-1:0]               mem_rdata,
  output logic                               busy
);

  localparam int LINE_BITS = ADDR_BITS - OFFSET_BITS;
  localparam int BEAT_W    = $clog2(BLOCK_SIZE);
  localparam int WB_W      = ADDR_BITS + WORD_SIZE;
  localparam int WB_CNT_W  = $clog2(WB_DEPTH) + 1;

  refill_state_t                 state;
  refill_state_t                 state_next;
  logic [LINE_BITS-1:0]          line_q;
  logic [BEAT_W-1:0]             beat_cnt;
  logic [WORD_SIZE*BLOCK_SIZE-1:0] line_buf;

  logic                          wb_push;
  logic                          wb_pop;
  logic                          wb_full;
  logic                          wb_empty;
  logic                          wb_empty_next;
  logic [WB_W-1:0]               wb_head;
  logic [WB_CNT_W-1:0]           wb_count;
  logic                          miss_hs;
  logic                          last_beat;

  cache_write_buffer #(
    .WIDTH (WB_W),
    .DEPTH (WB_DEPTH)
  ) u_wb (
    .clk       (clk),
    .resetn    (resetn),
    .push      (wb_push),
    .push_data ({wt_addr, wt_data}),
    .pop       (wb_pop),
    .head_data (wb_head),
    .full      (wb_full),
    .empty     (wb_empty),
    .count     (wb_count)
  );

  assign miss_ready = (state == IDLE);
  assign miss_hs    = miss_valid && miss_ready;
  assign wt_ready   = !wb_full && (state == IDLE);
  assign wb_push    = wt_valid && wt_ready;
  assign wb_pop     = mem_req_valid && mem_req_ready && mem_req_write;
  assign busy       = (state != IDLE) || !wb_empty;
  assign fill_line  = line_q;
  assign fill_data  = line_buf;
  assign last_beat  = mem_rvalid && (beat_cnt == BEAT_W'(BLOCK_SIZE - 1));

  // Occupancy after this cycle's push/pop decides whether a new miss has to
  // drain stores first. A pop implies non-empty, so only count==1 can empty.
  assign wb_empty_next = (wb_empty && !wb_push) ||
                         ((wb_count == WB_CNT_W'(1)) && wb_pop && !wb_push);

  always_comb begin
    state_next    = state;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = wb_head[WB_W-1 -: ADDR_BITS];
    mem_req_wdata = wb_head[WORD_SIZE-1:0];
    fill_valid    = 1'b0;
    case (state)
      IDLE: begin
        mem_req_valid = !wb_empty;
        mem_req_write = !wb_empty;
        if (miss_hs) begin
          state_next = wb_empty_next ? RD_REQ : DRAIN;
        end
      end
      DRAIN: begin
        mem_req_valid = !wb_empty;
        mem_req_write = !wb_empty;
        if (wb_empty) begin
          state_next = RD_REQ;
        end
      end
      RD_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {line_q, {OFFSET_BITS{1'b0}}};
        if (mem_req_ready) begin
          state_next = BEATS;
        end
      end
      BEATS: begin
        if (last_beat) begin
          state_next = FILL;
        end
      end
      FILL: begin
        fill_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      line_q   <= '0;
      beat_cnt <= '0;
      line_buf <= '0;
    end else begin
      state <= state_next;
      if (miss_hs) begin
        line_q <= miss_line;
      end
      if ((state == RD_REQ) && mem_req_ready) begin
        beat_cnt <= '0;
      end else if ((state == BEATS) && mem_rvalid) begin
        line_buf[int'(beat_cnt)*WORD_SIZE +: WORD_SIZE] <= mem_rdata;
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_line_refill_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_line_refill_unit
// Description : Self-checking bench for cache_line_refill_unit. A reference
//               model tracks pending stores as a queue, the outstanding refill
//               and the beats delivered, and checks every memory/fill event.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_line_refill_unit;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         miss_valid = 1'b0;
  logic         miss_ready;
  logic [16:0]  miss_line = '0;
  logic         fill_valid;
  logic [16:0]  fill_line;
  logic [255:0] fill_data;
  logic         wt_valid = 1'b0;
  logic         wt_ready;
  logic [21:0]  wt_addr = '0;
  logic [31:0]  wt_data = '0;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b0;
  logic         mem_req_write;
  logic [21:0]  mem_req_addr;
  logic [31:0]  mem_req_wdata;
  logic         mem_rvalid = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic         busy;

  always #5 clk = ~clk;

  cache_line_refill_unit #(
    .WORD_SIZE (32), .BLOCK_SIZE (8), .ADDR_BITS (22), .WB_DEPTH (4)
  ) dut (
    .clk (clk), .resetn (resetn),
    .miss_valid (miss_valid), .miss_ready (miss_ready), .miss_line (miss_line),
    .fill_valid (fill_valid), .fill_line (fill_line), .fill_data (fill_data),
    .wt_valid (wt_valid), .wt_ready (wt_ready), .wt_addr (wt_addr), .wt_data (wt_data),
    .mem_req_valid (mem_req_valid), .mem_req_ready (mem_req_ready),
    .mem_req_write (mem_req_write), .mem_req_addr (mem_req_addr),
    .mem_req_wdata (mem_req_wdata), .mem_rvalid (mem_rvalid), .mem_rdata (mem_rdata),
    .busy (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model
  typedef struct packed { logic [21:0] addr; logic [31:0] data; } store_t;
  store_t       exp_wr[$];
  bit           outstanding, burst_active;
  logic [16:0]  exp_line_addr;
  logic [255:0] exp_fill;
  logic [255:0] last_fill_data;
  logic [21:0]  last_rd_addr;
  int beat_k, beat_wait, fills, n_miss, writes_seen;
  int miss_hs_cyc, rd_hs_cyc, fill_cyc;
  bit miss_hs, wt_hs;
  bit prev_wait;
  logic [54:0] prev_req;

  // memory responder knobs
  int rdy_pct = 100, rdy_low = 0, gap_pct = 0, lat = 1;
  bit lat_rand = 0, seq_data = 0, stray_en = 0;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_wr.delete();
    outstanding  = 0;
    burst_active = 0;
    beat_k       = 0;
    prev_wait    = 0;
    miss_valid   = 0;
    wt_valid     = 0;
  endtask

  // Observes one cycle (called at the negedge, inputs stable).
  task automatic monitor();
    miss_hs = miss_valid && miss_ready;
    wt_hs   = wt_valid && wt_ready;
    chk("busy", busy, outstanding || (exp_wr.size() != 0));
    chk("miss_ready", miss_ready, !outstanding);
    chk("wt_ready", wt_ready, !outstanding && (exp_wr.size() < 4));
    if (prev_wait) begin
      chk("req_hold_valid", mem_req_valid, 1'b1);
      chk("req_hold_fields", {mem_req_write, mem_req_addr, mem_req_wdata}, prev_req);
    end
    prev_wait = mem_req_valid && !mem_req_ready;
    prev_req  = {mem_req_write, mem_req_addr, mem_req_wdata};
    if (mem_rvalid && burst_active) begin
      exp_fill[beat_k*32 +: 32] = mem_rdata;
      beat_k++;
      if (beat_k == 8) burst_active = 0;
    end
    if (mem_req_valid && mem_req_ready) begin
      if (mem_req_write) begin
        if (exp_wr.size() > 0) begin
          chk("wr_addr", mem_req_addr, exp_wr[0].addr);
          chk("wr_data", mem_req_wdata, exp_wr[0].data);
          void'(exp_wr.pop_front());
        end else begin
          chk("write_without_store", mem_req_write, 1'b0);
        end
        writes_seen++;
      end else begin
        chk("rd_when_refill_pending", outstanding && !burst_active, 1'b1);
        chk("rd_addr", mem_req_addr, {exp_line_addr, 5'b0});
        chk("rd_after_drain", exp_wr.size(), 0);
        last_rd_addr = mem_req_addr;
        burst_active = 1;
        beat_k       = 0;
        beat_wait    = lat_rand ? int'($urandom_range(3)) : lat - 1;
        rd_hs_cyc    = cyc;
      end
    end
    if (fill_valid) begin
      chk("fill_expected", fill_valid && outstanding && !burst_active && (beat_k == 8), 1'b1);
      chk("fill_line", fill_line, exp_line_addr);
      chk("fill_data", fill_data, exp_fill);
      last_fill_data = fill_data;
      outstanding = 0;
      fills++;
      fill_cyc = cyc;
    end
    if (wt_hs) exp_wr.push_back({wt_addr, wt_data});
    if (miss_hs) begin
      outstanding   = 1;
      exp_line_addr = miss_line;
      beat_k        = 0;
      miss_hs_cyc   = cyc;
      n_miss++;
    end
  endtask

  task automatic respond();
    if (rdy_low > 0) begin
      mem_req_ready = 1'b0;
      rdy_low--;
    end else begin
      mem_req_ready = ($urandom_range(99) < rdy_pct);
    end
    if (burst_active) begin
      if (beat_wait > 0) begin
        mem_rvalid = 1'b0;
        beat_wait--;
      end else if ($urandom_range(99) < gap_pct) begin
        mem_rvalid = 1'b0;
      end else begin
        mem_rvalid = 1'b1;
        mem_rdata  = seq_data ? 32'(32'h100 + beat_k) : $urandom;
      end
    end else begin
      mem_rvalid = stray_en && ($urandom_range(1) == 1);
      mem_rdata  = $urandom;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    if (miss_hs) miss_valid = 1'b0;
    if (wt_hs)   wt_valid   = 1'b0;
    respond();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    model_clear();
    repeat (2) tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic wait_fill(int budget, string name);
    int f0 = fills;
    int i  = 0;
    while (fills == f0 && i < budget) begin
      tick();
      i++;
    end
    chk(name, fills - f0, 1);
  endtask

  task automatic push_store(logic [21:0] a, logic [31:0] d);
    wt_valid = 1'b1;
    wt_addr  = a;
    wt_data  = d;
    tick();
  endtask

  typedef struct {
    logic        wv;
    logic [21:0] wa;
    logic [31:0] wd;
    logic        rdy;
    logic        e_wt_ready;
    logic        e_req_valid;
    logic [21:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_busy;
  } vec_t;
  vec_t vt[15];

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] seq_line;
    int f0, w0, i;

    do_reset();
    chk("rst_fill_valid", fill_valid, 1'b0);
    chk("rst_fill_line", fill_line, 17'h0);
    chk("rst_fill_data", fill_data, 256'h0);
    chk("rst_req_valid", mem_req_valid, 1'b0);

    // ---- write buffer fill / pop, table driven ----
    vt[0]  = '{0, 22'h0,  32'h0, 0, 1, 0, 22'h0,  32'h0, 0};
    vt[1]  = '{1, 22'h4,  32'hA, 0, 1, 0, 22'h0,  32'h0, 0};
    vt[2]  = '{1, 22'h8,  32'hB, 0, 1, 1, 22'h4,  32'hA, 1};
    vt[3]  = '{1, 22'hC,  32'hC, 0, 1, 1, 22'h4,  32'hA, 1};
    vt[4]  = '{1, 22'h10, 32'hD, 0, 1, 1, 22'h4,  32'hA, 1};
    vt[5]  = '{1, 22'h14, 32'hE, 0, 0, 1, 22'h4,  32'hA, 1};
    vt[6]  = '{0, 22'h0,  32'h0, 1, 0, 1, 22'h4,  32'hA, 1};
    vt[7]  = '{0, 22'h0,  32'h0, 0, 1, 1, 22'h8,  32'hB, 1};
    vt[8]  = '{1, 22'h18, 32'hF, 0, 1, 1, 22'h8,  32'hB, 1};
    vt[9]  = '{0, 22'h0,  32'h0, 0, 0, 1, 22'h8,  32'hB, 1};
    vt[10] = '{0, 22'h0,  32'h0, 1, 0, 1, 22'h8,  32'hB, 1};
    vt[11] = '{0, 22'h0,  32'h0, 1, 1, 1, 22'hC,  32'hC, 1};
    vt[12] = '{0, 22'h0,  32'h0, 1, 1, 1, 22'h10, 32'hD, 1};
    vt[13] = '{0, 22'h0,  32'h0, 1, 1, 1, 22'h18, 32'hF, 1};
    vt[14] = '{0, 22'h0,  32'h0, 0, 1, 0, 22'h0,  32'h0, 0};
    for (int r = 0; r < 15; r++) begin
      wt_valid      = vt[r].wv;
      wt_addr       = vt[r].wa;
      wt_data       = vt[r].wd;
      mem_req_ready = vt[r].rdy;
      #2;
      chk($sformatf("vec%0d_wt_ready", r), wt_ready, vt[r].e_wt_ready);
      chk($sformatf("vec%0d_req_valid", r), mem_req_valid, vt[r].e_req_valid);
      chk($sformatf("vec%0d_busy", r), busy, vt[r].e_busy);
      if (vt[r].e_req_valid)
        chk($sformatf("vec%0d_req", r), {mem_req_write, mem_req_addr, mem_req_wdata},
            {1'b1, vt[r].e_addr, vt[r].e_wdata});
      tick();
    end
    wt_valid = 1'b0;

    // ---- cold miss, exact latency, sequential beats ----
    do_reset();
    rdy_pct = 100; seq_data = 1; lat = 3; lat_rand = 0; gap_pct = 0;
    miss_valid = 1'b1;
    miss_line  = 17'h1A5C3;
    wait_fill(60, "t1_fill_seen");
    for (int k = 0; k < 8; k++) seq_line[k*32 +: 32] = 32'h100 + 32'(k);
    chk("t1_rd_addr", last_rd_addr, 22'h34B860);
    chk("t1_fill_data", last_fill_data, seq_line);
    chk("t1_rd_latency", rd_hs_cyc - miss_hs_cyc, 1);
    chk("t1_fill_latency", fill_cyc - miss_hs_cyc, 12);
    f0 = fills;
    repeat (4) tick();
    chk("t1_single_fill", fills - f0, 0);

    // ---- stores drain before the refill read ----
    seq_data = 0; lat = 1;
    rdy_pct = 0;
    w0 = writes_seen;
    push_store(22'h000004, 32'hA);
    push_store(22'h000008, 32'hB);
    push_store(22'h00000C, 32'hC);
    miss_valid = 1'b1;
    miss_line  = 17'h00123;
    rdy_pct    = 100;
    wait_fill(80, "t2_fill_seen");
    chk("t2_writes_before_read", writes_seen - w0, 3);

    // ---- request back-pressure and beat gaps ----
    miss_valid = 1'b1;
    miss_line  = 17'h0F0F0;
    rdy_low    = 6;
    gap_pct    = 40;
    lat_rand   = 1;
    wait_fill(200, "t4_fill_seen");
    chk("t4_ready_wait", rd_hs_cyc - miss_hs_cyc, 7);
    f0 = fills;
    repeat (4) tick();
    chk("t4_single_fill", fills - f0, 0);

    // ---- reset mid-burst, strays, discarded stores ----
    do_reset();
    gap_pct = 0; lat_rand = 0; lat = 1; rdy_pct = 100;
    miss_valid = 1'b1;
    miss_line  = 17'h0BEEF;
    i = 0;
    while (!(burst_active && beat_k >= 4) && i < 50) begin
      tick();
      i++;
    end
    chk("t5_reached_beat4", beat_k, 4);
    f0 = fills;
    resetn = 1'b0;
    model_clear();
    stray_en = 1;
    repeat (2) tick();
    resetn = 1'b1;
    repeat (6) tick();
    chk("t5_no_fill", fills - f0, 0);
    chk("t5_miss_ready", miss_ready, 1'b1);
    chk("t5_busy", busy, 1'b0);
    stray_en = 0;
    rdy_pct  = 0;
    push_store(22'h000100, 32'h11);
    push_store(22'h000104, 32'h22);
    w0 = writes_seen;
    resetn = 1'b0;
    model_clear();
    tick();
    resetn  = 1'b1;
    rdy_pct = 100;
    repeat (4) tick();
    chk("t5_wb_discarded", writes_seen - w0, 0);
    chk("t5_busy_after_discard", busy, 1'b0);
    miss_valid = 1'b1;
    miss_line  = 17'h1FFFF;
    wait_fill(60, "t5_next_miss_fill");

    // ---- strays in IDLE, miss together with the last write ----
    stray_en = 1;
    repeat (6) tick();
    stray_en = 0;
    rdy_pct  = 0;
    push_store(22'h000200, 32'h55);
    miss_valid    = 1'b1;
    miss_line     = 17'h00ABC;
    mem_req_ready = 1'b1;
    mem_rvalid    = 1'b1;
    rdy_pct       = 100;
    wait_fill(60, "t6_fill_seen");
    chk("t6_direct_rd_req", rd_hs_cyc - miss_hs_cyc, 1);

    // ---- randomized traffic against the model ----
    rdy_pct = 60; gap_pct = 25; lat_rand = 1; stray_en = 1;
    f0 = n_miss;
    w0 = fills;
    for (int c = 0; c < 3000; c++) begin
      if (!wt_valid && $urandom_range(99) < 30) begin
        wt_valid = 1'b1;
        wt_addr  = 22'($urandom);
        wt_data  = $urandom;
      end
      if (!miss_valid && !outstanding && $urandom_range(99) < 8) begin
        miss_valid = 1'b1;
        miss_line  = 17'($urandom);
      end
      tick();
    end
    wt_valid   = 1'b0;
    miss_valid = 1'b0;
    stray_en   = 0;
    i = 0;
    while ((outstanding || exp_wr.size() != 0) && i < 400) begin
      tick();
      i++;
    end
    tick();
    chk("rand_drained_busy", busy, 1'b0);
    chk("rand_fill_count", fills - w0, n_miss - f0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
